// File: rtl/alarm_controller.sv
// Arm / exit-delay / armed / entry-delay / alarm sequencer for the alarm sensor datapath.
// Optional build macro ALARM_AUTORESET_EN: ALARM returns to ARMED after ALARM_CYCLES.
module alarm_controller #(
    parameter int unsigned EXIT_CYCLES  = 16,
    parameter int unsigned ENTRY_CYCLES = 16,
    parameter int unsigned ALARM_CYCLES = 64,
    parameter int unsigned BLINK_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       trip,
    input  logic [3:0] zone,
    output logic       siren,
    output logic       chime,
    output logic       armed_led,
    output logic [2:0] state,
    output logic [3:0] zone_latch,
    output logic [3:0] alarm_count
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BDIV_W = 8;
    localparam int unsigned ZONE_W = 4;
    localparam int unsigned ACNT_W = 4;

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;

`ifdef ALARM_AUTORESET_EN
    localparam bit AUTORESET = 1'b1;
`else
    localparam bit AUTORESET = 1'b0;
`endif

    localparam logic [CNT_W-1:0]  EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [BDIV_W-1:0] BLINK_LAST = BDIV_W'(BLINK_DIV - 1);
    localparam logic [ACNT_W-1:0] ACNT_MAX   = '1;

    logic              trip_meta;
    logic              trip_s;
    logic [ZONE_W-1:0] zone_meta;
    logic [ZONE_W-1:0] zone_s;

    logic [2:0]        state_n;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_n;
    logic [BDIV_W-1:0] bdiv_q;
    logic [BDIV_W-1:0] bdiv_n;
    logic              chime_n;
    logic              siren_n;
    logic              armed_n;
    logic [ZONE_W-1:0] zone_latch_n;
    logic [ACNT_W-1:0] alarm_count_n;

    // State, counters, synchronisers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trip_meta   <= 1'b0;
            trip_s      <= 1'b0;
            zone_meta   <= '0;
            zone_s      <= '0;
            state       <= ST_DISARMED;
            cnt_q       <= '0;
            bdiv_q      <= '0;
            chime       <= 1'b0;
            siren       <= 1'b0;
            armed_led   <= 1'b0;
            zone_latch  <= '0;
            alarm_count <= '0;
        end else begin
            trip_meta   <= trip;
            trip_s      <= trip_meta;
            zone_meta   <= zone;
            zone_s      <= zone_meta;
            state       <= state_n;
            cnt_q       <= cnt_n;
            bdiv_q      <= bdiv_n;
            chime       <= chime_n;
            siren       <= siren_n;
            armed_led   <= armed_n;
            zone_latch  <= zone_latch_n;
            alarm_count <= alarm_count_n;
        end
    end

    // Next-state, shared timer and next-output logic
    always_comb begin
        state_n       = state;
        cnt_n         = cnt_q;
        bdiv_n        = bdiv_q;
        chime_n       = 1'b0;
        zone_latch_n  = zone_latch;
        alarm_count_n = alarm_count;

        if (state == ST_ENTRY || state == ST_ALARM) begin
            zone_latch_n = zone_latch | zone_s;
        end

        if (disarm) begin
            state_n = ST_DISARMED;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (arm) begin
                        state_n      = ST_EXIT;
                        cnt_n        = EXIT_LOAD;
                        zone_latch_n = '0;
                    end
                end
                ST_EXIT: begin
                    if (cnt_q == '0) state_n = ST_ARMED;
                    else             cnt_n   = cnt_q - CNT_W'(1);
                end
                ST_ARMED: begin
                    if (trip_s) begin
                        state_n      = ST_ENTRY;
                        cnt_n        = ENTRY_LOAD;
                        zone_latch_n = zone_latch | zone_s;
                    end
                end
                ST_ENTRY: begin
                    if (cnt_q == '0) begin
                        state_n = ST_ALARM;
                        cnt_n   = AUTORESET ? ALARM_LOAD : cnt_q;
                        if (alarm_count != ACNT_MAX) begin
                            alarm_count_n = alarm_count + ACNT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                ST_ALARM: begin
`ifdef ALARM_AUTORESET_EN
                    if (cnt_q == '0) state_n = ST_ARMED;
                    else             cnt_n   = cnt_q - CNT_W'(1);
`endif
                end
                default: state_n = ST_DISARMED;
            endcase
        end

        // Chime starts high on entry, then toggles every BLINK_DIV cycles
        if (state_n == ST_ENTRY) begin
            if (state != ST_ENTRY) begin
                chime_n = 1'b1;
                bdiv_n  = '0;
            end else if (bdiv_q == BLINK_LAST) begin
                chime_n = ~chime;
                bdiv_n  = '0;
            end else begin
                chime_n = chime;
                bdiv_n  = bdiv_q + BDIV_W'(1);
            end
        end

        siren_n = (state_n == ST_ALARM);
        armed_n = (state_n == ST_EXIT) || (state_n == ST_ARMED) ||
                  (state_n == ST_ENTRY) || (state_n == ST_ALARM);
    end

endmodule
